// File: rtl/tpu_seq_ctrl.sv
// Command sequencer for the systolic matrix unit. Accepts one command at a
// time: streams operand words into the array (LOAD_A/LOAD_B), fires a
// compute and waits for completion with a timeout (COMPUTE), or streams
// result words out of the array (STORE_C). Elements go row-major, col fastest.
module tpu_seq_ctrl #(
  parameter int DIM         = 32,
  parameter int IDX_W       = $clog2(DIM),
  parameter int TIMEOUT_CYC = 4096,
  parameter int DATA_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              abort_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [IDX_W-1:0]  cmd_rows_m1_i,
  input  logic [IDX_W-1:0]  cmd_cols_m1_i,
  input  logic              din_valid_i,
  output logic              din_ready_o,
  input  logic [DATA_W-1:0] din_data_i,
  output logic              dout_valid_o,
  input  logic              dout_ready_i,
  output logic [DATA_W-1:0] dout_data_o,
  output logic              tpu_start_o,
  output logic              tpu_wr_en_a_o,
  output logic              tpu_wr_en_b_o,
  output logic              tpu_wr_en_c_o,
  output logic [IDX_W-1:0]  tpu_row_o,
  output logic [IDX_W-1:0]  tpu_col_o,
  output logic [DATA_W-1:0] tpu_data_o,
  input  logic [DATA_W-1:0] tpu_data_i,
  input  logic              tpu_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;

  localparam logic [1:0] OP_LOAD_A  = 2'd0;
  localparam logic [1:0] OP_LOAD_B  = 2'd1;
  localparam logic [1:0] OP_COMPUTE = 2'd2;

  // Wide enough to hold TIMEOUT_CYC-1, the last count before giving up.
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [IDX_W-1:0] rows_q, rows_d;
  logic [IDX_W-1:0] cols_q, cols_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             xfer;
  logic             last;

  // Abort wins over command accept, so never advertise ready in that cycle.
  assign cmd_ready_o   = (state_q == S_IDLE) && !abort_i;
  assign din_ready_o   = (state_q == S_LOAD);
  assign dout_valid_o  = (state_q == S_STORE);
  assign dout_data_o   = dout_valid_o ? tpu_data_i : '0;
  assign tpu_start_o   = (state_q == S_START);
  assign tpu_wr_en_a_o = din_ready_o && din_valid_i && (op_q == OP_LOAD_A);
  assign tpu_wr_en_b_o = din_ready_o && din_valid_i && (op_q == OP_LOAD_B);
  assign tpu_wr_en_c_o = 1'b0;
  assign tpu_row_o     = row_q;
  assign tpu_col_o     = col_q;
  assign tpu_data_o    = din_ready_o ? din_data_i : '0;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;

  // Element handshake for the streaming states and last-element detect.
  always_comb begin
    xfer = 1'b0;
    if (state_q == S_LOAD) begin
      xfer = din_valid_i;
    end else if (state_q == S_STORE) begin
      xfer = dout_ready_i;
    end
    last = (row_q == rows_q) && (col_q == cols_q);
  end

  // Next-state logic; abort overrides whatever the state would have done.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    row_d   = row_q;
    col_d   = col_q;
    tcnt_d  = tcnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d   = cmd_op_i;
          rows_d = cmd_rows_m1_i;
          cols_d = cmd_cols_m1_i;
          row_d  = '0;
          col_d  = '0;
          err_d  = 1'b0;
          if (cmd_op_i == OP_LOAD_A || cmd_op_i == OP_LOAD_B) begin
            state_d = S_LOAD;
          end else if (cmd_op_i == OP_COMPUTE) begin
            state_d = S_START;
          end else begin
            state_d = S_STORE;
          end
        end
      end
      S_LOAD, S_STORE: begin
        if (xfer) begin
          if (last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            row_d   = '0;
            col_d   = '0;
          end else if (col_q == cols_q) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_START: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tpu_done_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tcnt_q == TO_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_i) begin
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = '0;
      tcnt_d  = '0;
      done_d  = 1'b0;
      err_d   = err_q;
    end
  end

  // State and counter registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      tcnt_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tcnt_q  <= tcnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Scoreboard bench for tpu_seq_ctrl: drivers push expected array writes,
// reads and completions into queues; a negedge monitor pops and compares.
module tb_tpu_seq_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        abort = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [4:0]  cmd_rows = '0;
  logic [4:0]  cmd_cols = '0;
  logic        din_valid = 1'b0;
  logic [31:0] din_data = '0;
  logic        dout_ready = 1'b0;
  logic        tpu_done = 1'b0;
  logic [31:0] salt = '0;

  logic        cmd_ready, din_ready, dout_valid;
  logic [31:0] dout_data, tpu_data_o, tpu_data_i;
  logic        tpu_start, wr_a, wr_b, wr_c, busy, done, err;
  logic [4:0]  tpu_row, tpu_col;

  always #5 clk = ~clk;

  // Array read-port model: content is a fixed function of (row,col) and a salt.
  function automatic logic [31:0] arr_word(input logic [4:0] r, input logic [4:0] c);
    return {8'hA5, 3'b000, r, 3'b000, c, 8'h3C};
  endfunction

  assign tpu_data_i = arr_word(tpu_row, tpu_col) ^ salt;

  tpu_seq_ctrl #(.DIM(32), .IDX_W(5), .TIMEOUT_CYC(TO), .DATA_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .abort_i(abort),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_rows_m1_i(cmd_rows), .cmd_cols_m1_i(cmd_cols),
    .din_valid_i(din_valid), .din_ready_o(din_ready), .din_data_i(din_data),
    .dout_valid_o(dout_valid), .dout_ready_i(dout_ready), .dout_data_o(dout_data),
    .tpu_start_o(tpu_start), .tpu_wr_en_a_o(wr_a), .tpu_wr_en_b_o(wr_b),
    .tpu_wr_en_c_o(wr_c), .tpu_row_o(tpu_row), .tpu_col_o(tpu_col),
    .tpu_data_o(tpu_data_o), .tpu_data_i(tpu_data_i), .tpu_done_i(tpu_done),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  typedef struct { logic b; logic [4:0] r; logic [4:0] c; logic [31:0] d; } wr_t;
  typedef struct { logic [4:0] r; logic [4:0] c; logic [31:0] d; } rd_t;
  typedef struct { logic err; int kind; int lat; } dn_t;

  wr_t exp_wr[$];
  rd_t exp_rd[$];
  dn_t exp_dn[$];
  int  exp_start = 0;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares every array access and completion against the queues.
  int          cyc = 0;
  int          start_cyc = 0;
  int          last_xfer = 0;
  logic        stall_q = 1'b0;
  logic [31:0] stall_d = '0;
  wr_t         mw;
  rd_t         mr;
  dn_t         md;

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (busy) begin
        chk("ready_while_busy", 32'(cmd_ready), 32'd0);
        chk("wr_en_c", 32'(wr_c), 32'd0);
      end
      if (wr_a || wr_b) begin
        if (exp_wr.size() == 0) begin
          chk("spurious_wr", 32'({wr_a, wr_b}), 32'd0);
        end else begin
          mw = exp_wr.pop_front();
          chk("wr_sel", 32'({wr_a, wr_b}), mw.b ? 32'd1 : 32'd2);
          chk("wr_row", 32'(tpu_row), 32'(mw.r));
          chk("wr_col", 32'(tpu_col), 32'(mw.c));
          chk("wr_data", tpu_data_o, mw.d);
          last_xfer = cyc;
        end
      end
      if (stall_q && dout_valid) chk("stall_stable", dout_data, stall_d);
      stall_q = dout_valid && !dout_ready;
      stall_d = dout_data;
      if (dout_valid && dout_ready) begin
        if (exp_rd.size() == 0) begin
          chk("spurious_rd", 32'(dout_valid), 32'd0);
        end else begin
          mr = exp_rd.pop_front();
          chk("rd_row", 32'(tpu_row), 32'(mr.r));
          chk("rd_col", 32'(tpu_col), 32'(mr.c));
          chk("rd_data", dout_data, mr.d);
          last_xfer = cyc;
        end
      end
      if (tpu_start) begin
        if (exp_start == 0) begin
          chk("spurious_start", 32'(tpu_start), 32'd0);
        end else begin
          exp_start--;
          start_cyc = cyc;
        end
      end
      if (done) begin
        if (exp_dn.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          md = exp_dn.pop_front();
          chk("done_err", 32'(err), 32'(md.err));
          chk("done_lat", 32'((md.kind == 1) ? (cyc - start_cyc) : (cyc - last_xfer)), 32'(md.lat));
          chk("idle_after_done", 32'({busy, cmd_ready}), 32'd1);
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_idle", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] rm, input logic [4:0] cm);
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_rows = rm; cmd_cols = cm;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_rows = 5'($urandom);
    cmd_cols = 5'($urandom);
    chk("cmd_accept", 32'(ok), 32'd1);
    if (ok) begin
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("err_clear_on_accept", 32'(err), 32'd0);
    end
  endtask

  task automatic do_load(input bit b, input int rm, input int cm, input int pct, input bit toggle);
    logic [31:0] words[$];
    wr_t w;
    dn_t d;
    int n, k, g;
    n = (rm + 1) * (cm + 1);
    for (int r = 0; r <= rm; r++) begin
      for (int c = 0; c <= cm; c++) begin
        w.b = b; w.r = 5'(r); w.c = 5'(c); w.d = $urandom;
        words.push_back(w.d);
        exp_wr.push_back(w);
      end
    end
    d.err = 1'b0; d.kind = 0; d.lat = 1;
    exp_dn.push_back(d);
    send_cmd(b ? 2'd1 : 2'd0, 5'(rm), 5'(cm));
    k = 0; g = 0;
    while (k < n && g < 500) begin
      din_valid = toggle ? (g % 2 == 0) : ($urandom_range(99) < 32'(pct));
      din_data = words[k];
      @(negedge clk);
      if (din_valid && din_ready) k++;
      @(posedge clk); #1;
      g++;
    end
    din_valid = 1'b0;
    chk("load_count", 32'(k), 32'(n));
    wait_idle();
  endtask

  task automatic do_store(input int rm, input int cm, input bit stall2);
    rd_t e;
    dn_t d;
    int n, k, g, st;
    salt = $urandom;
    n = (rm + 1) * (cm + 1);
    for (int r = 0; r <= rm; r++) begin
      for (int c = 0; c <= cm; c++) begin
        e.r = 5'(r); e.c = 5'(c); e.d = arr_word(5'(r), 5'(c)) ^ salt;
        exp_rd.push_back(e);
      end
    end
    d.err = 1'b0; d.kind = 0; d.lat = 1;
    exp_dn.push_back(d);
    send_cmd(2'd3, 5'(rm), 5'(cm));
    k = 0; g = 0; st = 0;
    while (k < n && g < 500) begin
      if (stall2) dout_ready = !(k == 1 && st < 3);
      else        dout_ready = ($urandom_range(99) < 70);
      @(negedge clk);
      if (dout_valid && dout_ready) k++;
      else if (dout_valid && stall2) st++;
      @(posedge clk); #1;
      g++;
    end
    dout_ready = 1'b0;
    chk("store_count", 32'(k), 32'(n));
    wait_idle();
  endtask

  task automatic wait_start();
    bit ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tpu_start) begin
        ok = 1'b1;
        break;
      end
    end
    chk("start_seen", 32'(ok), 32'd1);
  endtask

  // k = WAIT cycle (1-based) in which the array reports done.
  task automatic do_compute(input int k);
    dn_t d;
    exp_start++;
    d.err = (k > TO); d.kind = 1; d.lat = ((k > TO) ? TO : k) + 1;
    exp_dn.push_back(d);
    send_cmd(2'd2, 5'd0, 5'd0);
    wait_start();
    @(posedge clk); #1;
    repeat (k - 1) begin
      @(posedge clk); #1;
    end
    tpu_done = 1'b1;
    @(posedge clk); #1;
    tpu_done = 1'b0;
    wait_idle();
    if (k > TO) chk("err_sticky", 32'(err), 32'd1);
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_flags"}, 32'({tpu_start, wr_a, wr_b, wr_c, din_ready, dout_valid, done, err}), 32'd0);
    chk({tag, "_rowcol"}, 32'({tpu_row, tpu_col}), 32'd0);
    chk({tag, "_data"}, tpu_data_o, 32'd0);
  endtask

  // Abort after two of four elements, with a live handshake in the abort cycle.
  task automatic do_abort_load();
    wr_t w;
    logic [31:0] words[3];
    int k, g;
    for (int i = 0; i < 3; i++) begin
      w.b = 1'b0; w.r = 5'(i / 2); w.c = 5'(i % 2); w.d = $urandom;
      words[i] = w.d;
      exp_wr.push_back(w);
    end
    send_cmd(2'd0, 5'd1, 5'd1);
    k = 0; g = 0;
    while (k < 2 && g < 50) begin
      din_valid = 1'b1;
      din_data = words[k];
      @(negedge clk);
      if (din_ready) k++;
      @(posedge clk); #1;
      g++;
    end
    chk("abort_pre_count", 32'(k), 32'd2);
    din_valid = 1'b1; din_data = words[2]; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; din_valid = 1'b0;
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_rowcol", 32'({tpu_row, tpu_col}), 32'd0);
    chk("abort_err_kept", 32'(err), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1 rst_checks("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);

    do_load(1'b0, 1, 2, 100, 1'b0);
    do_load(1'b1, 1, 1, 0, 1'b1);
    do_compute(10);
    do_compute(20);
    do_store(0, 2, 1'b1);
    do_load(1'b0, 0, 0, 100, 1'b0);
    do_compute(TO);
    do_abort_load();
    do_load(1'b0, 1, 1, 100, 1'b0);

    for (int i = 0; i < 12; i++) begin
      int op, rm, cm;
      op = int'($urandom_range(3));
      rm = int'($urandom_range(3));
      cm = int'($urandom_range(3));
      case (op)
        0, 1:    do_load(op == 1, rm, cm, int'($urandom_range(100, 30)), 1'b0);
        2:       do_compute(int'($urandom_range(20, 1)));
        default: do_store(rm, cm, 1'b0);
      endcase
    end

    exp_start++;
    send_cmd(2'd2, 5'd0, 5'd0);
    wait_start();
    repeat (3) begin
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    #1 rst_checks("rst_mid_wait");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_load(1'b1, 0, 1, 80, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    chk("done_queue_empty", 32'(exp_dn.size()), 32'd0);
    chk("start_pending", 32'(exp_start), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tpu_seq_ctrl.md
Name: tpu_seq_ctrl

Overview:
Sequencer for the execute-stage systolic matrix unit (BITS_AB=16, BITS_C=32, DIM=32). It accepts one command at a time: LOAD_A, LOAD_B, COMPUTE or STORE_C. It streams operand words into the array by row/col, pulses start and waits for done with a timeout, and streams result words out. It sits between the pipeline/DMA front-end and the array, replacing direct per-instruction WrEn/row/col driving.

Parameters:
DIM, 32, array dimension; row/col counters span 0..DIM-1
IDX_W, 5, width of row/col index, equal to clog2(DIM)
TIMEOUT_CYC, 4096, max cycles waiting for tpu_done_i before error

Ports:
clk_i  input  1  clock
rst_n_i  input  1  asynchronous active-low reset
abort_i  input  1  synchronous abort; returns to IDLE next cycle
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command accepted when valid&ready
cmd_op_i  input  2  0=LOAD_A 1=LOAD_B 2=COMPUTE 3=STORE_C
cmd_rows_m1_i  input  IDX_W  rows minus 1 (LOAD/STORE)
cmd_cols_m1_i  input  IDX_W  cols minus 1 (LOAD/STORE)
din_valid_i  input  1  operand word valid
din_ready_o  output  1  operand word consumed when valid&ready
din_data_i  input  32  operand word
dout_valid_o  output  1  result word valid
dout_ready_i  input  1  result sink ready
dout_data_o  output  32  result word
tpu_start_o  output  1  array start pulse
tpu_wr_en_a_o  output  1  array A write enable
tpu_wr_en_b_o  output  1  array B write enable
tpu_wr_en_c_o  output  1  array C write enable (held 0; reserved)
tpu_row_o  output  IDX_W  array row index
tpu_col_o  output  IDX_W  array col index
tpu_data_o  output  32  array dataIn
tpu_data_i  input  32  array dataOut, valid combinationally for current row/col
tpu_done_i  input  1  array compute done
busy_o  output  1  state != IDLE
done_o  output  1  one-cycle pulse when a command completes
err_o  output  1  sticky timeout flag; cleared on next command accept

Behaviour:
- Reset is asynchronous, active-low: state=IDLE; row/col counters, limits, op and timeout counter=0; done_o=0; err_o=0; all tpu_* outputs=0.
- States: IDLE, LOAD, START, WAIT, STORE.
- IDLE: cmd_ready_o=1.
  - On accept, latch op and the rows_m1/cols_m1 limits, clear row/col to 0 and clear err_o.
  - LOAD_A/LOAD_B go to LOAD; COMPUTE goes to START; STORE_C goes to STORE.
- LOAD: din_ready_o=1.
  - tpu_data_o=din_data_i; tpu_row_o/tpu_col_o=counters.
  - tpu_wr_en_a_o (op LOAD_A) or tpu_wr_en_b_o (op LOAD_B) = din_valid_i, combinationally.
  - On each transfer, col increments; at col==cols_m1, col wraps to 0 and row increments.
  - A transfer at row==rows_m1 && col==cols_m1 is the last: go to IDLE and pulse done_o in the next cycle.
  - No transfer means counters hold.
- START: tpu_start_o=1 for exactly one cycle, timeout counter cleared, then go to WAIT.
- WAIT: timeout counter increments each cycle.
  - tpu_done_i=1 goes to IDLE with a done_o pulse.
  - If the counter reaches TIMEOUT_CYC-1 without done, set err_o, pulse done_o and go to IDLE.
  - If done and timeout hit in the same cycle, done wins and err_o stays 0.
- STORE: dout_valid_o=1; dout_data_o=tpu_data_i; tpu_row_o/tpu_col_o=counters.
  - A transfer is dout_valid_o&dout_ready_i; counters advance as in LOAD; last-element rule as in LOAD.
  - Outputs are stable while dout_ready_i=0.
- Outside LOAD, din_ready_o=0; outside STORE, dout_valid_o=0. Write enables are never asserted outside LOAD.
- Element order is row-major, col fastest. rows_m1=cols_m1=0 means a single element and completes after one transfer.
- abort_i has priority over every transition:
  - Next state is IDLE; counters clear; no done_o pulse; err_o unchanged.
  - A din/dout handshake in the abort cycle is still honoured as an array write/read but not counted.
- cmd_valid_i while busy is not accepted (cmd_ready_o=0). Latched limits do not change mid-command.
- Reset mid-command returns to IDLE asynchronously; array contents are not the controller's concern.

Test Plan:
- LOAD_A rows_m1=1, cols_m1=2, din always valid -> 6 cycles of wr_en_a, (row,col) = (0,0)(0,1)(0,2)(1,0)(1,1)(1,2); done_o the next cycle; cmd_ready_o back to 1.
- LOAD_B 2x2 with din_valid_i toggling every other cycle -> exactly 4 wr_en_b pulses with correct indices; counters hold on idle cycles; done after the 4th transfer.
- COMPUTE, tpu_done_i asserted 10 cycles after start -> single 1-cycle tpu_start_o; done_o one cycle after tpu_done_i; err_o=0.
- COMPUTE with TIMEOUT_CYC=16 and no done -> err_o=1 after 16 WAIT cycles plus a done_o pulse; next cmd accept clears err_o.
- STORE_C 1x3 with dout_ready_i low for 3 cycles on the 2nd element -> dout_data_o stable during stall; 3 words delivered in order; done_o pulse.
- abort_i during LOAD at element 2 of 4 -> IDLE next cycle, no done_o; a new LOAD restarts at (0,0); reset asserted mid-WAIT -> all outputs 0 immediately.
